// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state register and round counter, fetches round keys,
// and applies AddRoundKey around an external round datapath. Optional abort port: AES_ROUND_CTRL_ABORT_EN.
`timescale 1ns/1ps
module aes_round_ctrl #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          reset,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          key_req,
  output logic [RW-1:0] key_idx,
  input  logic          key_ack,
  input  logic [127:0]  rk,
  output logic [127:0]  dp_state,
  output logic          dp_last,
  input  logic [127:0]  dp_result,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [RW-1:0] LAST = RW'(NR);

  fsm_t          fsm;
  logic [RW-1:0] round;
  logic [127:0]  st;
  logic          abort_req;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_req = abort & (fsm != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // dp_result is only looked at on an acknowledged round >= 1, so X elsewhere never reaches st.
  always_ff @(posedge clk) begin
    if (reset || abort_req) begin
      fsm   <= IDLE;
      round <= '0;
      st    <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data;
            round <= '0;
            fsm   <= ROUND;
          end
        end
        ROUND: begin
          if (key_ack) begin
            if (round == '0) st <= st ^ rk;
            else             st <= dp_result ^ rk;
            if (round == LAST) fsm   <= DONE;
            else               round <= round + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm   <= IDLE;
            round <= '0;
          end
        end
        default: begin
          fsm   <= IDLE;
          round <= '0;
        end
      endcase
    end
  end

  // Handshake outputs decode the state register only; reset forces everything low.
  assign in_ready  = ~reset & (fsm == IDLE);
  assign key_req   = ~reset & (fsm == ROUND);
  assign out_valid = ~reset & (fsm == DONE);
  assign busy      = ~reset & (fsm != IDLE);
  assign key_idx   = key_req ? round : '0;
  assign dp_last   = key_req & (round == LAST);
  assign dp_state  = reset ? '0 : st;
  assign out_data  = out_valid ? st : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: FIPS-197 vectors through a bench-side AES round/key model,
// with stalls, back-pressure, back-to-back blocks, mid-block reset and (when enabled) abort.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int RW = 4;
  localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, key_req, key_ack, dp_last, busy;
  logic [127:0] in_data, out_data, rk, dp_state, dp_result;
  logic [RW-1:0] key_idx;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic abort;
`endif
  logic [127:0] rkeys [0:10];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .reset(reset),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_req(key_req), .key_idx(key_idx), .key_ack(key_ack), .rk(rk),
    .dp_state(dp_state), .dp_last(dp_last), .dp_result(dp_result), .busy(busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = '0; p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= p;
      p = xt(p);
    end
    return r;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r+4*c] = a[r+4*((c+r)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) a[4*c+r] = b[4*c+r];
      end else begin
        a[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
        a[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = a[i];
    return o;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, r == 10) ^ rkeys[r];
    return s;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= 10; k++) rkeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Key-expansion and datapath stand-ins; dp_result is X whenever the controller must not use it.
  assign rk        = (key_idx <= 4'd10) ? rkeys[key_idx] : '0;
  assign dp_result = (key_req && key_idx != '0) ? aes_round(dp_state, dp_last) : 'x;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({in_ready, out_valid, key_req, busy, dp_last} !== 5'b0) begin bad++;
      $display("FAIL reset_outputs: got %b want 00000", {in_ready, out_valid, key_req, busy, dp_last}); end
    total++; if (dp_state !== '0) begin bad++; $display("FAIL reset_state: got %h want 0", dp_state); end
    reset = 1'b0; #1;
    total++; if ({in_ready, busy, key_req, out_valid} !== 4'b1000) begin bad++;
      $display("FAIL after_reset: got %b want 1000", {in_ready, busy, key_req, out_valid}); end
  endtask

  task automatic test_fips();
    key_ack = 1'b1; out_ready = 1'b0;
    in_data = PT; in_valid = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk); in_valid = 1'b0;
      if (n <= 11) begin
        total++; if (key_req !== 1'b1 || key_idx !== RW'(n-1)) begin bad++;
          $display("FAIL fips_key_idx: cycle %0d got req=%b idx=%0d want req=1 idx=%0d", n, key_req, key_idx, n-1); end
        total++; if (dp_last !== (n == 11)) begin bad++;
          $display("FAIL fips_dp_last: cycle %0d got %b want %b", n, dp_last, n == 11); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fips_early_out: cycle %0d got 1 want 0", n); end
      end
    end
    total++; if (out_valid !== 1'b1 || key_req !== 1'b0) begin bad++;
      $display("FAIL fips_out_valid: got valid=%b req=%b want valid=1 req=0", out_valid, key_req); end
    total++; if (out_data !== CT) begin bad++; $display("FAIL fips_ct: got %h want %h", out_data, CT); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    total++; if ({busy, in_ready, out_valid} !== 3'b010) begin bad++;
      $display("FAIL fips_idle: got busy/in_ready/out_valid=%b want 010", {busy, in_ready, out_valid}); end
  endtask

  task automatic test_stall();
    logic [127:0] prev;
    key_ack = 1'b0; out_ready = 1'b0;
    in_data = PT; in_valid = 1'b1;
    prev = '0;
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk); in_valid = 1'b0;
      if (n <= 33) begin
        total++; if (key_req !== 1'b1 || key_idx !== RW'((n-1)/3)) begin bad++;
          $display("FAIL stall_idx: cycle %0d got req=%b idx=%0d want req=1 idx=%0d", n, key_req, key_idx, (n-1)/3); end
        if (n % 3 != 1) begin
          total++; if (dp_state !== prev) begin bad++;
            $display("FAIL stall_hold: cycle %0d got %h want %h", n, dp_state, prev); end
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_early_out: cycle %0d got 1 want 0", n); end
      end
      prev = dp_state;
      key_ack = (n % 3 == 0);
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid: got %b want 1", out_valid); end
    total++; if (out_data !== CT) begin bad++; $display("FAIL stall_ct: got %h want %h", out_data, CT); end
    key_ack = 1'b1; out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    key_ack = 1'b1; out_ready = 1'b0;
    in_data = PT; in_valid = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) in_valid = 1'b0;
      if (n >= 12 && n <= 17) begin
        total++; if (out_valid !== 1'b1 || out_data !== CT) begin bad++;
          $display("FAIL bp_hold: cycle %0d got valid=%b data=%h want valid=1 data=%h", n, out_valid, out_data, CT); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: cycle %0d got 1 want 0", n); end
      end
      if (n == 13) begin in_valid = 1'b1; in_data = PT2; end
      if (n == 16) in_valid = 1'b0;
      if (n == 17) out_ready = 1'b1;
    end
    out_ready = 1'b0;
    total++; if ({busy, in_ready, out_valid} !== 3'b010) begin bad++;
      $display("FAIL bp_idle: got busy/in_ready/out_valid=%b want 010", {busy, in_ready, out_valid}); end
    total++; if (dp_state !== CT) begin bad++; $display("FAIL bp_not_captured: got %h want %h", dp_state, CT); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] ct2;
    int acc [$];
    int outs;
    ct2 = aes_encrypt(PT2);
    outs = 0;
    key_ack = 1'b1; out_ready = 1'b1;
    in_data = PT; in_valid = 1'b1;
    for (int n = 0; n <= 28; n++) begin
      if (n > 0) @(negedge clk);
      if (n == 1) in_data = PT2;
      if (acc.size() == 2 && n > acc[1]) in_valid = 1'b0;
      if (in_ready && in_valid) acc.push_back(n);
      if (out_valid) begin
        outs++;
        total++;
        if (n == 12) begin
          if (out_data !== CT) begin bad++; $display("FAIL b2b_ct1: got %h want %h", out_data, CT); end
        end else if (n == 25) begin
          if (out_data !== ct2) begin bad++; $display("FAIL b2b_ct2: got %h want %h", out_data, ct2); end
        end else begin
          bad++; $display("FAIL b2b_out_timing: out_valid at cycle %0d want 12 or 25", n);
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (acc.size() != 2 || acc[1] - acc[0] != 13) begin bad++;
      $display("FAIL b2b_accept_gap: got %0d accepts, gap %0d want 2 accepts, gap 13", acc.size(),
               (acc.size() == 2) ? acc[1] - acc[0] : -1); end
    total++; if (outs != 2) begin bad++; $display("FAIL b2b_out_count: got %0d want 2", outs); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    key_ack = 1'b1; out_ready = 1'b0;
    in_data = PT; in_valid = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk); in_valid = 1'b0;
    end
    total++; if (key_idx !== RW'(5)) begin bad++; $display("FAIL rmid_round: got %0d want 5", key_idx); end
    reset = 1'b1; #1;
    total++; if ({in_ready, key_req, busy, out_valid} !== 4'b0000) begin bad++;
      $display("FAIL rmid_during: got %b want 0000", {in_ready, key_req, busy, out_valid}); end
    @(negedge clk); reset = 1'b0; #1;
    total++; if ({busy, in_ready, key_req} !== 3'b010) begin bad++;
      $display("FAIL rmid_after: got busy/in_ready/key_req=%b want 010", {busy, in_ready, key_req}); end
    total++; if (dp_state !== '0) begin bad++; $display("FAIL rmid_state: got %h want 0", dp_state); end
    in_data = PT; in_valid = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk); in_valid = 1'b0;
      if (n < 12 && out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0 || out_valid !== 1'b1 || out_data !== CT) begin bad++;
      $display("FAIL rmid_fresh: got early=%b valid=%b data=%h want early=0 valid=1 data=%h", seen, out_valid, out_data, CT); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

`ifdef AES_ROUND_CTRL_ABORT_EN
  task automatic test_abort();
    logic seen;
    key_ack = 1'b1; out_ready = 1'b0;
    in_data = PT; in_valid = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk); in_valid = 1'b0;
    end
    total++; if (key_idx !== RW'(7)) begin bad++; $display("FAIL abort_round: got %0d want 7", key_idx); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    total++; if ({busy, in_ready, out_valid} !== 3'b010) begin bad++;
      $display("FAIL abort_idle: got busy/in_ready/out_valid=%b want 010", {busy, in_ready, out_valid}); end
    total++; if (dp_state !== '0) begin bad++; $display("FAIL abort_state: got %h want 0", dp_state); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_out: got out_valid=1 want 0"); end
    in_data = PT; in_valid = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk); in_valid = 1'b0;
    end
    total++; if (out_valid !== 1'b1 || out_data !== CT) begin bad++;
      $display("FAIL abort_next_ct: got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, CT); end
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; key_ack = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    expand_key(KEY);
    test_reset();
    test_fips();
    test_stall();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_ROUND_CTRL_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES-128 encryption sequencer. Owns the 128-bit state register and round counter, and fetches round keys from the key-expansion block via a request/ack handshake. Drives the shared combinational round datapath (SubBytes -> ShiftRows -> MixColumns, with MixColumns bypassed in the last round) and applies AddRoundKey itself. Sits between the block-level valid/ready stream interface and the round datapath.

Parameters:
NR, 10, number of rounds after the initial AddRoundKey (10 = AES-128).
RW, 4, round counter / key index width; must satisfy 2^RW > NR.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  plaintext valid.
in_ready  output  1  controller can accept plaintext.
in_data  input  128  plaintext, byte 0 in [127:120].
out_valid  output  1  ciphertext valid.
out_ready  input  1  downstream accepts ciphertext.
out_data  output  128  ciphertext.
key_req  output  1  round key request.
key_idx  output  RW  requested round key index, 0..NR.
key_ack  input  1  round key present on rk this cycle.
rk  input  128  round key.
dp_state  output  128  current state register, fed to the round datapath.
dp_last  output  1  final round; datapath must bypass MixColumns.
dp_result  input  128  combinational datapath result for dp_state (before AddRoundKey).
busy  output  1  FSM not in IDLE.

Behaviour:
- FSM states are IDLE, ROUND and DONE. Registers are fsm, round[RW-1:0] and st[127:0].
- Reset (synchronous) sets fsm=IDLE, round=0 and st=0. While reset is high, every output is 0, including in_ready.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: st<=in_data, round<=0, fsm<=ROUND.
  - in_valid in any other state is ignored and not captured.
- ROUND:
  - key_req=1 and key_idx=round.
  - The FSM stalls with all registers held until key_ack=1.
  - On key_ack with round==0: st<=st^rk.
  - On key_ack with round>=1: st<=dp_result^rk.
  - On key_ack, if round==NR then fsm<=DONE; otherwise round<=round+1.
  - dp_state=st at all times. dp_last=1 only when fsm==ROUND and round==NR.
  - dp_result is sampled only on key_ack cycles with round>=1; an X value at other times must not propagate.
- DONE:
  - out_valid=1 and out_data=st. Both are held stable under back-pressure.
  - On out_ready: fsm<=IDLE and round<=0. st is retained.
- key_ack is ignored whenever key_req=0.
- busy = (fsm!=IDLE).
- key_req, out_valid and in_ready are decoded from fsm only; there is no combinational path from in_valid or out_ready.
- Latency with key_ack tied high:
  - Accept at cycle T. Rounds 0..NR run at T+1..T+NR+1.
  - out_valid rises at T+NR+2 (T+12 for NR=10).
  - The earliest next accept is the cycle after the out handshake.
- Reset asserted in any state returns to IDLE on the next edge. A partially processed block is discarded and no out_valid is produced.
- round never exceeds NR, so there is no wrap-around.

Optional Feature:
- Macro: AES_ROUND_CTRL_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - abort=1 in ROUND or DONE forces fsm<=IDLE, round<=0 and st<=0 on the next edge. No out_valid is produced for the aborted block.
  - abort in IDLE has no effect.
  - Reset has priority over abort.
  - abort has priority over key_ack and out_ready in the same cycle.
- Not defined: the port is absent and the behaviour is as above.

Test Plan:
- FIPS-197 App. B vector: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, key_ack tied 1, bench model for datapath and key schedule -> out_data=3925841d02dc09fbdc118597196a0b32, out_valid exactly 12 cycles after accept, key_idx sequence 0..10, dp_last high only at key_idx=10.
- Same vector with key_ack pulsed every 3rd cycle -> identical ciphertext; st and round hold during stalls; out_valid 34 cycles after accept.
- out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable for all 5 cycles; in_ready=0 throughout; a second in_valid during this time is not captured.
- Back-to-back blocks with out_ready=1 and in_valid=1 continuously -> accepts 13 cycles apart; both ciphertexts correct.
- Reset asserted at round 5 -> next cycle: busy=0, in_ready=1, key_req=0; a fresh block then produces the correct ciphertext.
- (ABORT_EN) abort at round 7 with key_ack=1 in the same cycle -> IDLE next cycle, st=0, no out_valid; the next block encrypts correctly.
